// File: rtl/ec_miter_ctrl.sv
// Equivalence-miter sequencer: warm-up, exhaustive 2^NIN stimulus sweep, LAT-aligned golden/revised compare, summary.
// All outputs registered; done lands WARM+2^NIN+LAT+1 cycles after start. No backpressure; abort ends a run early.
module ec_miter_ctrl #(
  parameter int NIN  = 2,
  parameter int LAT  = 1,
  parameter int WARM = 2,
  parameter int CW   = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  input  logic           gld_x,
  input  logic           rvs_x,
  output logic [NIN-1:0] stim,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [CW-1:0]  mism_cnt,
  output logic           fail_valid,
  output logic [NIN-1:0] first_fail
);

  typedef enum logic [2:0] {S_IDLE, S_WARM, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [31:0] NVEC_M1 = 32'((1 << NIN) - 1);
  localparam logic [31:0] WARM_M1 = 32'(WARM - 1);
  localparam logic [31:0] LAT_M1  = 32'(LAT - 1);

  state_t         state_q, state_d;
  logic [31:0]    cnt_q, cnt_d;
  logic [NIN-1:0] stim_q, stim_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           pass_q, pass_d;
  logic [CW-1:0]  mism_q, mism_d;
  logic           fv_q, fv_d;
  logic [NIN-1:0] ff_q, ff_d;
  logic           sr_vld_q [LAT];
  logic [NIN-1:0] sr_vec_q [LAT];
  logic           in_run, abort_hit, cmp_en;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pass_d    = pass_q;
    mism_d    = mism_q;
    fv_d      = fv_q;
    ff_d      = ff_q;
    in_run    = (state_q == S_WARM) || (state_q == S_RUN) || (state_q == S_DRAIN);
    abort_hit = in_run && abort;
    // An abort discards whatever compare would have landed on this edge.
    cmp_en    = sr_vld_q[LAT-1] && in_run && !abort;

    if (cmp_en && (gld_x != rvs_x)) begin
      if (mism_q != {CW{1'b1}}) mism_d = mism_q + 1'b1;
      if (!fv_q) begin
        fv_d = 1'b1;
        ff_d = sr_vec_q[LAT-1];
      end
    end

    case (state_q)
      S_IDLE: if (start) begin
        pass_d  = 1'b0;
        mism_d  = '0;
        fv_d    = 1'b0;
        ff_d    = '0;
        cnt_d   = '0;
        state_d = (WARM == 0) ? S_RUN : S_WARM;
      end
      S_WARM: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == WARM_M1) begin
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == NVEC_M1) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == LAT_M1) begin
          cnt_d   = '0;
          state_d = S_DONE;
          pass_d  = !fv_d;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort_hit) begin
      state_d = S_DONE;
      cnt_d   = '0;
      pass_d  = 1'b0;
    end

    // Outputs are registered from next state so they line up with the state they describe.
    stim_d = (state_d == S_RUN) ? cnt_d[NIN-1:0] : '0;
    busy_d = (state_d == S_WARM) || (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      stim_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      mism_q  <= '0;
      fv_q    <= 1'b0;
      ff_q    <= '0;
      for (int i = 0; i < LAT; i++) begin
        sr_vld_q[i] <= 1'b0;
        sr_vec_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stim_q  <= stim_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      mism_q  <= mism_d;
      fv_q    <= fv_d;
      ff_q    <= ff_d;
      if (abort_hit) begin
        for (int i = 0; i < LAT; i++) begin
          sr_vld_q[i] <= 1'b0;
          sr_vec_q[i] <= '0;
        end
      end else begin
        for (int i = LAT - 1; i > 0; i--) begin
          sr_vld_q[i] <= sr_vld_q[i-1];
          sr_vec_q[i] <= sr_vec_q[i-1];
        end
        // Only vectors presented during RUN are tagged for comparison.
        sr_vld_q[0] <= (state_q == S_RUN);
        sr_vec_q[0] <= stim_q;
      end
    end
  end

  assign stim       = stim_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign mism_cnt   = mism_q;
  assign fail_valid = fv_q;
  assign first_fail = ff_q;

endmodule

// File: tb/tb_ec_miter_ctrl.sv
// Scoreboarded bench for ec_miter_ctrl: per-cycle trace and per-run result queues checked by monitors.
module tb_ec_miter_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, abort, gld_x, rvs_x;
  logic [1:0] stim, first_fail;
  logic       busy, done, pass, fail_valid;
  logic [7:0] mism_cnt;

  logic       start_s, gld_s, rvs_s;
  logic [1:0] stim_s, ff_s, mism_s;
  logic       busy_s, done_s, pass_s, fv_s;

  ec_miter_ctrl u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .gld_x(gld_x), .rvs_x(rvs_x), .stim(stim), .busy(busy), .done(done),
    .pass(pass), .mism_cnt(mism_cnt), .fail_valid(fail_valid), .first_fail(first_fail)
  );

  ec_miter_ctrl #(.CW(2)) u_sat (
    .clk(clk), .rst(rst), .start(start_s), .abort(1'b0),
    .gld_x(gld_s), .rvs_x(rvs_s), .stim(stim_s), .busy(busy_s), .done(done_s),
    .pass(pass_s), .mism_cnt(mism_s), .fail_valid(fv_s), .first_fail(ff_s)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural golden/revised pair: registered OR of the stimulus; mode 1 stubs revised to 0.
  int   mode = 0;
  logic flip = 1'b0;
  logic gld_r = 1'b0, rvs_r = 1'b0;
  always @(posedge clk) begin
    gld_r <= stim[0] | stim[1];
    rvs_r <= (mode == 1) ? 1'b0 : (stim[0] | stim[1]);
    gld_s <= stim_s[0] | stim_s[1];
    rvs_s <= ~(stim_s[0] | stim_s[1]);
  end
  assign gld_x = gld_r;
  assign rvs_x = rvs_r ^ flip;

  typedef struct {
    int         cyc;
    logic       busy;
    logic       done;
    logic [1:0] stim;
    logic       chk;
    logic       pass;
    logic [7:0] mism;
    logic       fv;
    logic [1:0] ff;
  } tr_t;

  typedef struct {
    int         cyc;
    logic       pass;
    logic [7:0] mism;
    logic       fv;
    logic [1:0] ff;
  } res_t;

  tr_t  trq[$];
  res_t resq[$];
  res_t ressq[$];
  tr_t  me;
  res_t mr;
  res_t ms;
  int   tests = 0;
  int   fails = 0;
  int   t0;

  task automatic push_tr(input int c, input logic b, input logic d, input logic [1:0] s,
                         input logic ck, input logic p, input logic [7:0] m,
                         input logic f, input logic [1:0] ff);
    tr_t e;
    e.cyc = c; e.busy = b; e.done = d; e.stim = s;
    e.chk = ck; e.pass = p; e.mism = m; e.fv = f; e.ff = ff;
    trq.push_back(e);
  endtask

  // Nominal run shape for NIN=2, LAT=1, WARM=2: busy 1..7, stim 0..3 in cycles 3..6, done at 8.
  task automatic push_run(input int base, input int last, input logic p, input logic [7:0] m,
                          input logic f, input logic [1:0] ff);
    for (int j = 1; j <= last; j++) begin
      logic [1:0] sv;
      sv = (j >= 3 && j <= 6) ? 2'(j - 3) : 2'd0;
      push_tr(base + j, (j <= 7), (j == 8), sv, (j == 9), p, m, f, ff);
    end
  endtask

  task automatic push_res(input int c, input logic p, input logic [7:0] m,
                          input logic f, input logic [1:0] ff);
    res_t r;
    r.cyc = c; r.pass = p; r.mism = m; r.fv = f; r.ff = ff;
    resq.push_back(r);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    while (trq.size() > 0 && trq[0].cyc <= cyc) begin
      me = trq.pop_front();
      tests++;
      if (me.cyc != cyc || busy !== me.busy || done !== me.done || stim !== me.stim ||
          (me.chk && (pass !== me.pass || mism_cnt !== me.mism ||
                      fail_valid !== me.fv || first_fail !== me.ff))) begin
        fails++;
        $display("FAIL trace c%0d@%0d: got busy=%b done=%b stim=%0d pass=%b mism=%0d fv=%b ff=%0d, want busy=%b done=%b stim=%0d pass=%b mism=%0d fv=%b ff=%0d (res chk=%b)",
                 me.cyc, cyc, busy, done, stim, pass, mism_cnt, fail_valid, first_fail,
                 me.busy, me.done, me.stim, me.pass, me.mism, me.fv, me.ff, me.chk);
      end
    end
    if (done === 1'b1) begin
      tests++;
      if (resq.size() == 0) begin
        fails++;
        $display("FAIL result: unexpected done at cycle %0d", cyc);
      end else begin
        mr = resq.pop_front();
        if (cyc != mr.cyc || pass !== mr.pass || mism_cnt !== mr.mism ||
            fail_valid !== mr.fv || first_fail !== mr.ff) begin
          fails++;
          $display("FAIL result: got cyc=%0d pass=%b mism=%0d fv=%b ff=%0d, want cyc=%0d pass=%b mism=%0d fv=%b ff=%0d",
                   cyc, pass, mism_cnt, fail_valid, first_fail, mr.cyc, mr.pass, mr.mism, mr.fv, mr.ff);
        end
      end
    end
    if (done_s === 1'b1) begin
      tests++;
      if (ressq.size() == 0) begin
        fails++;
        $display("FAIL sat_result: unexpected done at cycle %0d", cyc);
      end else begin
        ms = ressq.pop_front();
        if (cyc != ms.cyc || pass_s !== ms.pass || {6'd0, mism_s} !== ms.mism ||
            fv_s !== ms.fv || ff_s !== ms.ff) begin
          fails++;
          $display("FAIL sat_result: got cyc=%0d pass=%b mism=%0d fv=%b ff=%0d, want cyc=%0d pass=%b mism=%0d fv=%b ff=%0d",
                   cyc, pass_s, mism_s, fv_s, ff_s, ms.cyc, ms.pass, ms.mism, ms.fv, ms.ff);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b1; abort = 1'b0; start_s = 1'b0;
    // Reset held two edges with start asserted: start must be ignored.
    tick(); tick();
    push_tr(cyc, 0, 0, 2'd0, 1, 0, 8'd0, 0, 2'd0);
    push_tr(cyc + 1, 0, 0, 2'd0, 1, 0, 8'd0, 0, 2'd0);
    rst = 1'b0; start = 1'b0;
    tick(); tick();

    // Equivalent pair, with the CW=2 instance running an all-mismatch sweep alongside.
    mode = 0; t0 = cyc;
    start = 1'b1; start_s = 1'b1;
    push_run(t0, 9, 1, 8'd0, 0, 2'd0);
    push_res(t0 + 8, 1, 8'd0, 0, 2'd0);
    begin
      res_t r;
      r.cyc = t0 + 8; r.pass = 0; r.mism = 8'd3; r.fv = 1; r.ff = 2'd0;
      ressq.push_back(r);
    end
    tick(); start = 1'b0; start_s = 1'b0;
    repeat (10) tick();

    // Stubbed revised model; start re-pulsed mid-run must be ignored.
    mode = 1; t0 = cyc;
    start = 1'b1;
    push_run(t0, 9, 0, 8'd3, 1, 2'd1);
    push_res(t0 + 8, 0, 8'd3, 1, 2'd1);
    tick(); start = 1'b0;
    tick(); tick(); tick();
    start = 1'b1;
    tick(); start = 1'b0;
    repeat (6) tick();

    // Warm-up masking: disagreement confined to cycles 1..3.
    mode = 0; t0 = cyc;
    start = 1'b1;
    push_run(t0, 9, 1, 8'd0, 0, 2'd0);
    push_res(t0 + 8, 1, 8'd0, 0, 2'd0);
    tick(); start = 1'b0; flip = 1'b1;
    tick(); tick(); tick();
    flip = 1'b0;
    repeat (6) tick();

    // Abort (with coincident start) at cycle 4: done at 5, pass forced low.
    mode = 1; t0 = cyc;
    start = 1'b1;
    push_run(t0, 4, 0, 8'd0, 0, 2'd0);
    push_tr(t0 + 5, 0, 1, 2'd0, 1, 0, 8'd0, 0, 2'd0);
    push_tr(t0 + 6, 0, 0, 2'd0, 1, 0, 8'd0, 0, 2'd0);
    push_res(t0 + 5, 0, 8'd0, 0, 2'd0);
    tick(); start = 1'b0;
    tick(); tick(); tick();
    start = 1'b1; abort = 1'b1;
    tick(); start = 1'b0; abort = 1'b0;
    repeat (4) tick();

    // Reset asserted in cycle 5 of a run: cycle 6 onward is idle with cleared outputs.
    mode = 1; t0 = cyc;
    start = 1'b1;
    push_run(t0, 5, 0, 8'd0, 0, 2'd0);
    push_tr(t0 + 6, 0, 0, 2'd0, 1, 0, 8'd0, 0, 2'd0);
    push_tr(t0 + 7, 0, 0, 2'd0, 1, 0, 8'd0, 0, 2'd0);
    tick(); start = 1'b0;
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    tick(); rst = 1'b0;
    repeat (6) tick();

    while (trq.size() > 0) begin
      me = trq.pop_front();
      tests++; fails++;
      $display("FAIL trace_left: cycle %0d never checked, now %0d", me.cyc, cyc);
    end
    while (resq.size() > 0) begin
      mr = resq.pop_front();
      tests++; fails++;
      $display("FAIL result_left: done expected at cycle %0d never seen", mr.cyc);
    end
    while (ressq.size() > 0) begin
      ms = ressq.pop_front();
      tests++; fails++;
      $display("FAIL sat_result_left: done expected at cycle %0d never seen", ms.cyc);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ec_miter_ctrl.md
# ec_miter_ctrl

Sequencer for one equivalence-check miter: drives a shared stimulus vector into a golden/revised DUT pair, waits out their register latency, compares their outputs, and reports a pass/fail summary. It sits above two instances that share `a`/`b` inputs and each produce a registered 1-bit `x`. It replaces hand-written benches for exhaustive small-input equivalence runs.

## Interface
Parameters:
- `NIN`, 2: stimulus width. 2^NIN vectors are issued per run.
- `LAT`, 1: DUT latency in cycles from stimulus to output, ≥1.
- `WARM`, 2: warm-up cycles before the first vector, ≥0. Lets internal DUT registers settle from unknown reset state.
- `CW`, 8: mismatch counter width.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  begin run. Sampled in IDLE only.
- `abort`  in  1  terminate run early. Sampled in WARM/RUN/DRAIN.
- `gld_x`  in  1  golden DUT output.
- `rvs_x`  in  1  revised DUT output.
- `stim`  out  NIN  stimulus driven to both DUTs' inputs.
- `busy`  out  1  high in WARM, RUN, DRAIN.
- `done`  out  1  one-cycle pulse at run end.
- `pass`  out  1  run result, valid from `done` until the next accepted `start`.
- `mism_cnt`  out  CW  count of mismatching vectors, saturating.
- `fail_valid`  out  1  at least one mismatch seen this run.
- `first_fail`  out  NIN  stimulus of the first mismatching vector.

## Operation
- States: IDLE → WARM → RUN → DRAIN → DONE → IDLE.
- IDLE: `stim`=0, `busy`=0. When `start`=1 at an edge:
  - clear `pass`, `mism_cnt`, `fail_valid`, `first_fail`;
  - go to WARM, or to RUN if WARM=0.
- WARM: hold `stim`=0 for WARM cycles. No compares.
- RUN: `stim` = 0, 1, …, 2^NIN−1, one value per cycle, in order. After the last vector, go to DRAIN.
- DRAIN: LAT cycles with `stim`=0, so the last vectors get compared. Then go to DONE.
- DONE: `done`=1 and `busy`=0 for one cycle. `pass` = NOT `fail_valid` (and not aborted). Then go to IDLE.
- Compare alignment:
  - Internal shift register of depth LAT carries (valid, vector).
  - A vector issued in cycle k is compared using `gld_x`/`rvs_x` sampled at the edge ending cycle k+LAT.
  - Only RUN-issued vectors are valid. WARM and DRAIN slots are masked.
- On a valid compare with `gld_x` ≠ `rvs_x`:
  - `mism_cnt` += 1, saturating at 2^CW−1;
  - if `fail_valid`=0, latch `first_fail` = vector and set `fail_valid`.
- `abort`=1 in WARM/RUN/DRAIN: next state is DONE. `pass`=0. Counts gathered so far are kept. In-flight compares are discarded.
- `start` outside IDLE is ignored. `abort` in IDLE/DONE is ignored. If `abort` and the RUN→DRAIN transition coincide, `abort` wins.
- `rst`: next cycle is IDLE, all outputs at reset values, shift register cleared. This applies mid-run too.

## Timing
- Reset values: `stim`=0, `busy`=0, `done`=0, `pass`=0, `mism_cnt`=0, `fail_valid`=0, `first_fail`=0.
- `start` accepted at the edge ending cycle 0. Then:
  - `busy` is high in cycles 1 … WARM+2^NIN+LAT;
  - `done` is high in cycle WARM+2^NIN+LAT+1.
- `stim` and all outputs are registered. No combinational path from inputs to outputs.
- Result outputs are final in the DONE cycle and hold until the next accepted `start`.
- The next `start` can be accepted in the cycle after DONE.

## Test plan
All scenarios use defaults: NIN=2, LAT=1, WARM=2.
- Reset: hold `rst` for 2 cycles → all outputs 0, state IDLE; `start` while `rst`=1 is ignored.
- Equivalent pair: `gld_x`=`rvs_x`= registered (`stim[0]`|`stim[1]`), `start` at cycle 0 → `stim` 0,1,2,3 in cycles 3–6, `busy` in cycles 1–7, `done` at cycle 8, `pass`=1, `mism_cnt`=0, `fail_valid`=0.
- Stubbed revised model: `rvs_x`= registered 0, `gld_x` as above → `mism_cnt`=3, `first_fail`=2'b01, `fail_valid`=1, `pass`=0.
- Warm-up masking: force `gld_x`≠`rvs_x` in cycles 1–3 only, equivalent otherwise → `pass`=1, `mism_cnt`=0.
- Abort/ignore: `start` re-pulsed at cycle 4 has no effect; `abort` at cycle 4 → `done` at cycle 5, `pass`=0, `busy`=0 from cycle 5.
- Reset mid-run and saturation: `rst` at cycle 5 → IDLE in cycle 6 with all outputs 0. Separately, CW=2 with all 4 vectors mismatching → `mism_cnt`=3 (saturated), `first_fail`=0.
